// File: rtl/multicycle_control_fsm_if.sv
// Handshake/control bundle between the multi-cycle sequencer and the datapath.
// master = sequencer side, slave = instruction RAM / datapath side.
interface multicycle_control_fsm_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
);
  logic [DATA_W-1:0]     instr;
  logic                  instrValid;
  logic                  memReady;

  logic                  irLoad;
  logic                  pcEnable;
  logic [REG_ADDR_W-1:0] regSrcSelect;
  logic [REG_ADDR_W-1:0] regDestSelect;
  logic                  shftOrNormMuxEnable;
  logic                  regOrImmediateMuxEnable;
  logic [1:0]            immediateSignZeroMuxEnable;
  logic                  aluOrOtherMuxEnable;
  logic                  ramOrRegDestMuxEnable;
  logic                  regWriteEnable;
  logic                  flagWriteEnable;
  logic                  memWriteEnable;
  logic                  illegalOp;
  logic [2:0]            state;

  modport master (
    input  instr, instrValid, memReady,
    output irLoad, pcEnable, regSrcSelect, regDestSelect,
           shftOrNormMuxEnable, regOrImmediateMuxEnable,
           immediateSignZeroMuxEnable, aluOrOtherMuxEnable,
           ramOrRegDestMuxEnable, regWriteEnable, flagWriteEnable,
           memWriteEnable, illegalOp, state
  );

  modport slave (
    output instr, instrValid, memReady,
    input  irLoad, pcEnable, regSrcSelect, regDestSelect,
           shftOrNormMuxEnable, regOrImmediateMuxEnable,
           immediateSignZeroMuxEnable, aluOrOtherMuxEnable,
           ramOrRegDestMuxEnable, regWriteEnable, flagWriteEnable,
           memWriteEnable, illegalOp, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Registered FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit datapath.
// Optional MEM_WAIT_EN: MEM stalls until memReady; otherwise MEM is one cycle.
//
// state  | meaning
// FETCH  | wait for instrValid, latch IR, pulse irLoad/pcEnable
// DECODE | selects driven from IR, illegalOp pulse on bad encodings
// EXEC   | ALU operation in flight; JAL writes link and loads PC
// MEM    | data RAM access (LOAD / STOR)
// WB     | register and/or flag writeback
module multicycle_control_fsm #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int IMM_W      = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  localparam logic [2:0] ST_FETCH  = 3'b000;
  localparam logic [2:0] ST_DECODE = 3'b001;
  localparam logic [2:0] ST_EXEC   = 3'b010;
  localparam logic [2:0] ST_MEM    = 3'b011;
  localparam logic [2:0] ST_WB     = 3'b100;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEMOP = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_JAL  = 4'b1000;
  localparam logic [3:0] EXT_CMP  = 4'b1011;

  localparam logic [2:0] CL_ILL  = 3'd0;
  localparam logic [2:0] CL_ALU  = 3'd1;
  localparam logic [2:0] CL_LOAD = 3'd2;
  localparam logic [2:0] CL_STOR = 3'd3;
  localparam logic [2:0] CL_JAL  = 3'd4;

  localparam logic [1:0] IMM_ONLY = 2'b00;
  localparam logic [1:0] IMM_SIGN = 2'b01;
  localparam logic [1:0] IMM_ZERO = 2'b10;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [DATA_W-1:0] r_ir;

  logic [3:0] w_opcode;
  logic [3:0] w_ext;
  logic [2:0] w_cls;
  logic       w_shft;
  logic       w_roi;
  logic [1:0] w_imm_sel;
  logic       w_aoo;
  logic       w_rord;
  logic       w_mem_done;
  logic       w_ir_load;
  logic       w_active;
  logic       w_in_decode;
  logic       w_in_exec;
  logic       w_in_mem;
  logic       w_in_wb;

  // Extension nibble sits in the top of the immediate field.
  assign w_opcode = r_ir[DATA_W-1 -: 4];
  assign w_ext    = r_ir[IMM_W-1 -: 4];

  always_comb begin
    w_cls     = CL_ILL;
    w_shft    = 1'b0;
    w_roi     = 1'b0;
    w_imm_sel = IMM_ONLY;
    w_aoo     = 1'b0;
    w_rord    = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_cls  = CL_ALU;
        w_shft = 1'b1;
        w_rord = (w_ext != EXT_CMP);
      end
      OP_ADDI, OP_ADDUI, OP_SUBI, OP_CMPI: begin
        w_cls     = CL_ALU;
        w_shft    = 1'b1;
        w_roi     = 1'b1;
        w_imm_sel = IMM_SIGN;
        w_rord    = (w_opcode != OP_CMPI);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: begin
        w_cls     = CL_ALU;
        w_shft    = 1'b1;
        w_roi     = 1'b1;
        w_imm_sel = IMM_ZERO;
        w_rord    = 1'b1;
      end
      OP_LUI: begin
        w_cls  = CL_ALU;
        w_shft = 1'b1;
        w_roi  = 1'b1;
        w_rord = 1'b1;
      end
      OP_MEMOP: begin
        case (w_ext)
          EXT_LOAD: begin
            w_cls  = CL_LOAD;
            w_aoo  = 1'b1;
            w_rord = 1'b1;
          end
          EXT_STOR: w_cls = CL_STOR;
          EXT_JAL: begin
            w_cls  = CL_JAL;
            w_aoo  = 1'b1;
            w_rord = 1'b1;
          end
          default: w_cls = CL_ILL;
        endcase
      end
      default: w_cls = CL_ILL;
    endcase
  end

`ifdef MEM_WAIT_EN
  assign w_mem_done = bus.memReady;
`else
  logic w_unused_mem_ready;
  assign w_mem_done         = 1'b1;
  assign w_unused_mem_ready = bus.memReady;
`endif

  always_comb begin
    w_state_nxt = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_state_nxt = bus.instrValid ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (w_cls)
          CL_ALU, CL_JAL:   w_state_nxt = ST_EXEC;
          CL_LOAD, CL_STOR: w_state_nxt = ST_MEM;
          default:          w_state_nxt = ST_FETCH;
        endcase
      end
      ST_EXEC:   w_state_nxt = (w_cls == CL_JAL) ? ST_FETCH : ST_WB;
      ST_MEM: begin
        if (!w_mem_done)
          w_state_nxt = ST_MEM;
        else if (w_cls == CL_LOAD)
          w_state_nxt = ST_WB;
        else
          w_state_nxt = ST_FETCH;
      end
      default:   w_state_nxt = ST_FETCH;
    endcase
  end

  // Gated by rst_n so no FETCH pulse leaks out while reset is held.
  assign w_ir_load = rst_n & (r_state == ST_FETCH) & bus.instrValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_load)
        r_ir <= bus.instr;
    end
  end

  assign w_in_decode = (r_state == ST_DECODE);
  assign w_in_exec   = (r_state == ST_EXEC);
  assign w_in_mem    = (r_state == ST_MEM);
  assign w_in_wb     = (r_state == ST_WB);
  assign w_active    = w_in_decode | w_in_exec | w_in_mem | w_in_wb;

  assign bus.state                      = r_state;
  assign bus.irLoad                     = w_ir_load;
  assign bus.pcEnable                   = w_ir_load | (w_in_exec & (w_cls == CL_JAL));
  assign bus.regSrcSelect               = w_active ? r_ir[REG_ADDR_W-1:0] : '0;
  assign bus.regDestSelect              = w_active ? r_ir[8 +: REG_ADDR_W] : '0;
  assign bus.shftOrNormMuxEnable        = w_active & w_shft;
  assign bus.regOrImmediateMuxEnable    = w_active & w_roi;
  assign bus.immediateSignZeroMuxEnable = w_active ? w_imm_sel : IMM_ONLY;
  assign bus.aluOrOtherMuxEnable        = w_active & w_aoo;
  assign bus.ramOrRegDestMuxEnable      = w_active & w_rord;
  assign bus.regWriteEnable             = (w_in_wb & w_rord) | (w_in_exec & (w_cls == CL_JAL));
  assign bus.flagWriteEnable            = w_in_wb & (w_cls == CL_ALU);
  assign bus.memWriteEnable             = w_in_mem & (w_cls == CL_STOR);
  assign bus.illegalOp                  = w_in_decode & (w_cls == CL_ILL);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed vector table, corner
// sequences (reset in WB, STOR stall under MEM_WAIT_EN) and randomized traffic.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_ld;
    logic       pc_en;
    logic [3:0] src;
    logic [3:0] dest;
    logic       shft;
    logic       roi;
    logic [1:0] imm;
    logic       aoo;
    logic       rord;
    logic       rw;
    logic       fw;
    logic       mw;
    logic       ill;
  } out_t;

  typedef struct {
    logic [15:0] ins;
    logic        iv;
    logic        mr;
    out_t        ex;
  } vec_t;

  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;
  localparam int K_ILL = 0, K_ALU = 1, K_CMP = 2, K_LOAD = 3, K_STOR = 4, K_JAL = 5;
`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  out_t last_act;

  int          ph_q[$];
  logic [15:0] m_ir;
  vec_t        tv[$];

  multicycle_control_fsm_if #(.DATA_W(16), .REG_ADDR_W(4)) bus ();

  multicycle_control_fsm #(.DATA_W(16), .REG_ADDR_W(4), .IMM_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t a;
    a = {bus.state, bus.irLoad, bus.pcEnable, bus.regSrcSelect, bus.regDestSelect,
         bus.shftOrNormMuxEnable, bus.regOrImmediateMuxEnable,
         bus.immediateSignZeroMuxEnable, bus.aluOrOtherMuxEnable,
         bus.ramOrRegDestMuxEnable, bus.regWriteEnable, bus.flagWriteEnable,
         bus.memWriteEnable, bus.illegalOp};
    return a;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t e(input logic [2:0] st, input logic irl, input logic pc,
                             input logic [3:0] src, input logic [3:0] dest,
                             input logic shft, input logic roi, input logic [1:0] imm,
                             input logic aoo, input logic rord, input logic rw,
                             input logic fw, input logic mw, input logic ill);
    out_t o;
    o = {st, irl, pc, src, dest, shft, roi, imm, aoo, rord, rw, fw, mw, ill};
    return o;
  endfunction

  task automatic add(input logic [15:0] ins, input logic iv, input logic mr, input out_t ex);
    vec_t v;
    v.ins = ins; v.iv = iv; v.mr = mr; v.ex = ex;
    tv.push_back(v);
  endtask

  // ---------------- reference model: instruction class -> phase list ----------------
  function automatic int kind_of(input logic [15:0] ins);
    logic [3:0] op, ext;
    op  = ins[15:12];
    ext = ins[7:4];
    if (op == 4'h0) return (ext == 4'hB) ? K_CMP : K_ALU;
    if (op == 4'hB) return K_CMP;
    if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hD, 4'hF}) return K_ALU;
    if (op == 4'h4) begin
      if (ext == 4'h0) return K_LOAD;
      if (ext == 4'h4) return K_STOR;
      if (ext == 4'h8) return K_JAL;
    end
    return K_ILL;
  endfunction

  function automatic logic [1:0] imm_of(input logic [3:0] op);
    if (op inside {4'h5, 4'h6, 4'h9, 4'hB}) return 2'b01;
    if (op inside {4'h1, 4'h2, 4'h3, 4'hD}) return 2'b10;
    return 2'b00;
  endfunction

  function automatic out_t model_exp(input logic iv);
    out_t o;
    int   ph, k;
    o = '0;
    ph = (ph_q.size() == 0) ? PH_F : ph_q[0];
    if (ph == PH_F) begin
      o.ir_ld = iv;
      o.pc_en = iv;
      return o;
    end
    k      = kind_of(m_ir);
    o.st   = 3'(ph);
    o.src  = m_ir[3:0];
    o.dest = m_ir[11:8];
    case (k)
      K_ALU, K_CMP: begin
        o.shft = 1'b1;
        o.roi  = (m_ir[15:12] != 4'h0);
        o.imm  = imm_of(m_ir[15:12]);
        o.rord = (k == K_ALU);
      end
      K_LOAD, K_JAL: begin
        o.aoo  = 1'b1;
        o.rord = 1'b1;
      end
      K_ILL: o.ill = (ph == PH_D);
      default: ;
    endcase
    if (ph == PH_W) begin
      o.rw = (k == K_ALU) || (k == K_LOAD);
      o.fw = (k == K_ALU) || (k == K_CMP);
    end
    if (ph == PH_E && k == K_JAL) begin
      o.rw    = 1'b1;
      o.pc_en = 1'b1;
    end
    if (ph == PH_M && k == K_STOR) o.mw = 1'b1;
    return o;
  endfunction

  task automatic model_advance(input logic [15:0] ins, input logic iv, input logic mr);
    int ph;
    ph = (ph_q.size() == 0) ? PH_F : ph_q[0];
    if (ph == PH_F) begin
      if (iv) begin
        m_ir = ins;
        case (kind_of(ins))
          K_ALU, K_CMP: begin ph_q.push_back(PH_D); ph_q.push_back(PH_E); ph_q.push_back(PH_W); end
          K_LOAD:       begin ph_q.push_back(PH_D); ph_q.push_back(PH_M); ph_q.push_back(PH_W); end
          K_STOR:       begin ph_q.push_back(PH_D); ph_q.push_back(PH_M); end
          K_JAL:        begin ph_q.push_back(PH_D); ph_q.push_back(PH_E); end
          default:      ph_q.push_back(PH_D);
        endcase
      end
    end else if (!(ph == PH_M && WAIT_EN && !mr)) begin
      void'(ph_q.pop_front());
    end
  endtask

  // Inputs are driven 1 time unit after posedge, outputs sampled on negedge.
  task automatic cycle(input logic [15:0] ins, input logic iv, input logic mr, input string name);
    out_t ex;
    bus.instr      = ins;
    bus.instrValid = iv;
    bus.memReady   = mr;
    ex = model_exp(iv);
    @(negedge clk);
    last_act = sample();
    check(name, last_act, ex);
    model_advance(ins, iv, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.instrValid = 1'b0;
    ph_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int mem_cycles, mw_cnt, rw_seen;
    out_t z;
    z = '0;

    // Reset held with instrValid high: nothing may be driven.
    rst_n          = 1'b0;
    bus.instr      = 16'h5123;
    bus.instrValid = 1'b1;
    bus.memReady   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", sample(), z);
    @(negedge clk);
    check("reset_hold_neg", sample(), z);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    bus.instrValid = 1'b0;

    // ADDI 0x5123
    add(16'h5123, 1, 1, e(0,1,1, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h5123, 1, 1, e(1,0,0, 4'h3,4'h1, 1,1,2'b01, 0,1, 0,0,0, 0));
    add(16'h5123, 1, 1, e(2,0,0, 4'h3,4'h1, 1,1,2'b01, 0,1, 0,0,0, 0));
    add(16'h5123, 1, 1, e(4,0,0, 4'h3,4'h1, 1,1,2'b01, 0,1, 1,1,0, 0));
    add(16'h0000, 0, 1, z);
    // illegal opcode 0x7000
    add(16'h7000, 1, 1, e(0,1,1, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h7000, 1, 1, e(1,0,0, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 1));
    add(16'h7000, 0, 1, z);
    // CMPI 0xB2FF then five idle FETCH cycles
    add(16'hB2FF, 1, 1, e(0,1,1, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 0));
    add(16'hB2FF, 1, 1, e(1,0,0, 4'hF,4'h2, 1,1,2'b01, 0,0, 0,0,0, 0));
    add(16'hB2FF, 1, 1, e(2,0,0, 4'hF,4'h2, 1,1,2'b01, 0,0, 0,0,0, 0));
    add(16'hB2FF, 1, 1, e(4,0,0, 4'hF,4'h2, 1,1,2'b01, 0,0, 0,1,0, 0));
    for (int i = 0; i < 5; i++) add(16'hB2FF, 0, 1, z);
    // LOAD 0x4203
    add(16'h4203, 1, 1, e(0,1,1, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h4203, 1, 1, e(1,0,0, 4'h3,4'h2, 0,0,2'b00, 1,1, 0,0,0, 0));
    add(16'h4203, 1, 1, e(3,0,0, 4'h3,4'h2, 0,0,2'b00, 1,1, 0,0,0, 0));
    add(16'h4203, 1, 1, e(4,0,0, 4'h3,4'h2, 0,0,2'b00, 1,1, 1,0,0, 0));
    add(16'h0000, 0, 1, z);
    // JAL 0x4180
    add(16'h4180, 1, 1, e(0,1,1, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h4180, 1, 1, e(1,0,0, 4'h0,4'h1, 0,0,2'b00, 1,1, 0,0,0, 0));
    add(16'h4180, 1, 1, e(2,0,1, 4'h0,4'h1, 0,0,2'b00, 1,1, 1,0,0, 0));
    add(16'h0000, 0, 1, z);
    // ORI 0x2745 (zero-ext)
    add(16'h2745, 1, 1, e(0,1,1, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h2745, 1, 1, e(1,0,0, 4'h5,4'h7, 1,1,2'b10, 0,1, 0,0,0, 0));
    add(16'h2745, 1, 1, e(2,0,0, 4'h5,4'h7, 1,1,2'b10, 0,1, 0,0,0, 0));
    add(16'h2745, 1, 1, e(4,0,0, 4'h5,4'h7, 1,1,2'b10, 0,1, 1,1,0, 0));
    // R-type CMP 0x0AB5: flags only, register operand
    add(16'h0AB5, 1, 1, e(0,1,1, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h0AB5, 1, 1, e(1,0,0, 4'h5,4'hA, 1,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h0AB5, 1, 1, e(2,0,0, 4'h5,4'hA, 1,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h0AB5, 1, 1, e(4,0,0, 4'h5,4'hA, 1,0,2'b00, 0,0, 0,1,0, 0));
    // 0100 with undefined extension is illegal
    add(16'h4C20, 1, 1, e(0,1,1, 4'h0,4'h0, 0,0,2'b00, 0,0, 0,0,0, 0));
    add(16'h4C20, 1, 1, e(1,0,0, 4'h0,4'hC, 0,0,2'b00, 0,0, 0,0,0, 1));
    add(16'h0000, 0, 1, z);

    for (int i = 0; i < tv.size(); i++) begin
      bus.instr      = tv[i].ins;
      bus.instrValid = tv[i].iv;
      bus.memReady   = tv[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d", i), sample(), tv[i].ex);
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of ADDI writeback.
    do_reset();
    cycle(16'h5123, 1, 1, "rst_seq_f");
    cycle(16'h5123, 1, 1, "rst_seq_d");
    cycle(16'h5123, 1, 1, "rst_seq_e");
    bus.instrValid = 1'b1;
    @(negedge clk);
    check("rst_seq_wb", sample(), e(4,0,0, 4'h3,4'h1, 1,1,2'b01, 0,1, 1,1,0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_wb", sample(), z);
    ph_q.delete();
    @(posedge clk);
    #1;
    check("rst_held", sample(), z);
    rst_n          = 1'b1;
    bus.instrValid = 1'b0;
    @(negedge clk);
    check("rst_release", sample(), z);
    @(posedge clk);
    #1;

    // STOR 0x4345 with memReady low for three MEM cycles.
    do_reset();
    cycle(16'h4345, 1, 0, "stor_f");
    cycle(16'h4345, 0, 0, "stor_d");
    mem_cycles = 0;
    mw_cnt     = 0;
    rw_seen    = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(16'h4345, 0, (k >= 3), $sformatf("stor_mem%0d", k));
      if (last_act.st == 3'd3) mem_cycles++;
      if (last_act.mw) mw_cnt++;
      if (last_act.rw) rw_seen++;
    end
    check_int("stor_mem_cycles", mem_cycles, WAIT_EN ? 4 : 1);
    check_int("stor_memwrite_cycles", mw_cnt, WAIT_EN ? 4 : 1);
    check_int("stor_no_regwrite", rw_seen, 0);

    // Randomized traffic against the phase-list model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  op, ext;
      logic [15:0] ins;
      case ($urandom_range(0, 3))
        0:       ext = 4'h0;
        1:       ext = 4'h4;
        2:       ext = 4'h8;
        default: ext = 4'($urandom_range(0, 15));
      endcase
      op  = 4'($urandom_range(0, 15));
      ins = {op, 4'($urandom_range(0, 15)), ext, 4'($urandom_range(0, 15))};
      cycle(ins, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            $sformatf("rand%0d_%h", n, ins));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
